// File: rtl/io_port_controller_if.sv
// Data-bus interface shared by the MEM-stage data memory and the I/O port block.
// master: processor side (address/data/strobes); slave: peripheral (ReadData, IOSel).
interface io_port_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  IOSel;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, IOSel
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, IOSel
  );

endinterface

// File: rtl/io_port_controller.sv
// Memory-mapped I/O port: PORTOUT (0x00 RW), PORTIN (0x04 RO), STATUS (0x08 RW1C).
// Ports: clk, reset (async active-low), bus (slave: Address/WriteData/MemWrite/MemRead
// in, ReadData/IOSel out), PortIn (async pins), PortOut, InChanged.
// Optional macro IO_PORTOUT_SETCLR_EN adds write-only SET (0x0C) and CLR (0x10).
module io_port_controller #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          PORT_IN_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR     = 32'h1001_0000,
  parameter int          ADDR_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  io_port_controller_if.slave      bus,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [DATA_WIDTH-1:0]    PortOut,
  output logic                     InChanged
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [DATA_WIDTH-1:0]    port_q, port_d;
  logic [PORT_IN_WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic                     flag_q, flag_d;
  logic [7:0]               cnt_q, cnt_d;

  logic [2:0]  off;
  logic        base_hit;
  logic        sel_out, sel_in, sel_st;
  logic        chg;
  logic        wr_st;
  logic [15:0] status;
  logic        unused_addr;

`ifdef IO_PORTOUT_SETCLR_EN
  logic sel_set, sel_clr;
`endif

  assign off         = bus.Address[4:2];
  assign base_hit    = bus.Address[ADDR_WIDTH-1:5] == BASE[ADDR_WIDTH-1:5];
  assign unused_addr = ^bus.Address[1:0];

  always_comb begin
    sel_out = 1'b0;
    sel_in  = 1'b0;
    sel_st  = 1'b0;
`ifdef IO_PORTOUT_SETCLR_EN
    sel_set = 1'b0;
    sel_clr = 1'b0;
`endif
    case (off)
      3'd0: sel_out = base_hit;
      3'd1: sel_in  = base_hit;
      3'd2: sel_st  = base_hit;
`ifdef IO_PORTOUT_SETCLR_EN
      3'd3: sel_set = base_hit;
      3'd4: sel_clr = base_hit;
`endif
      default: ;
    endcase
  end

`ifdef IO_PORTOUT_SETCLR_EN
  assign bus.IOSel = sel_out | sel_in | sel_st | sel_set | sel_clr;
`else
  assign bus.IOSel = sel_out | sel_in | sel_st;
`endif

  assign status = {cnt_q, 7'd0, flag_q};

  // Selects are mutually exclusive; SET/CLR fall to default and read 0.
  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead) begin
      unique case (1'b1)
        sel_out: bus.ReadData = port_q;
        sel_in:  bus.ReadData = DATA_WIDTH'(sync2_q);
        sel_st:  bus.ReadData = DATA_WIDTH'(status);
        default: ;
      endcase
    end
  end

  always_comb begin
    port_d = port_q;
`ifdef IO_PORTOUT_SETCLR_EN
    if (bus.MemWrite) begin
      unique case (1'b1)
        sel_out: port_d = bus.WriteData;
        sel_set: port_d = port_q | bus.WriteData;
        sel_clr: port_d = port_q & ~bus.WriteData;
        default: ;
      endcase
    end
`else
    if (bus.MemWrite && sel_out) port_d = bus.WriteData;
`endif
  end

  assign chg   = sync2_q != prev_q;
  assign wr_st = bus.MemWrite & sel_st;

  // A new change wins over a same-cycle clear, for both flag and counter.
  assign flag_d = chg | (flag_q & ~(wr_st & bus.WriteData[0]));
  assign cnt_d  = ((wr_st & bus.WriteData[1]) ? 8'd0 : cnt_q)
                + {7'd0, chg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      port_q  <= port_d;
      sync1_q <= PortIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PortOut   = port_q;
  assign InChanged = flag_q;

endmodule

// File: tb/tb_io_port_controller.sv
// Self-checking bench for io_port_controller: directed scenarios plus random
// bus/pin traffic compared every cycle against a behavioural model.
module tb_io_port_controller;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] PortIn = 8'h00;
  logic [31:0] PortOut;
  logic       InChanged;
  logic       cmp_en = 1'b0;
  int         pass = 0;
  int         total = 0;

  io_port_controller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  io_port_controller #(
    .DATA_WIDTH(32), .PORT_IN_WIDTH(8),
    .BASE_ADDR(BASE), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus),
    .PortIn(PortIn), .PortOut(PortOut), .InChanged(InChanged)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pout = '0;
  logic        m_flag = 1'b0;
  logic [7:0]  m_cnt  = '0;
  logic [7:0]  pins[$];

  // Pins sampled at each edge since reset; the visible value lags two edges.
  function automatic logic [7:0] m_sync2();
    if (pins.size() >= 2) return pins[pins.size()-2];
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_prev();
    if (pins.size() >= 3) return pins[pins.size()-3];
    return 8'h00;
  endfunction

  function automatic int m_reg(input logic [31:0] a);
    int idx;
    if (a[31:5] != BASE[31:5]) return -1;
    idx = int'(a[4:2]);
    if (idx <= 2) return idx;
`ifdef IO_PORTOUT_SETCLR_EN
    if (idx == 3 || idx == 4) return idx;
`endif
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pout = '0; m_flag = 1'b0; m_cnt = '0;
        pins.delete();
      end else begin
        automatic bit chg = m_sync2() != m_prev();
        automatic int r = m_reg(bus.Address);
        automatic bit wr = bus.MemWrite && r >= 0;
        automatic bit stw = wr && r == 2;
        if (wr && r == 0) m_pout = bus.WriteData;
        if (wr && r == 3) m_pout = m_pout | bus.WriteData;
        if (wr && r == 4) m_pout = m_pout & ~bus.WriteData;
        if (chg) m_flag = 1'b1;
        else if (stw && bus.WriteData[0]) m_flag = 1'b0;
        m_cnt = ((stw && bus.WriteData[1]) ? 8'd0 : m_cnt) + 8'(chg);
        pins.push_back(PortIn);
        if (pins.size() > 3) void'(pins.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        automatic int r = m_reg(bus.Address);
        automatic logic [31:0] er = 32'h0;
        if (bus.MemRead && r == 0) er = m_pout;
        if (bus.MemRead && r == 1) er = {24'h0, m_sync2()};
        if (bus.MemRead && r == 2) er = {16'h0, m_cnt, 7'h0, m_flag};
        chk("cyc_IOSel", {31'h0, bus.IOSel}, {31'h0, r >= 0});
        chk("cyc_ReadData", bus.ReadData, er);
        chk("cyc_PortOut", PortOut, m_pout);
        chk("cyc_InChanged", {31'h0, InChanged}, {31'h0, m_flag});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MemWrite = 1'b0;
    bus.MemRead = 1'b0;
    bus.Address = 32'h0;
    bus.WriteData = 32'h0;
  endtask

  task automatic wr(input int o, input logic [31:0] d);
    bus.Address = BASE + 32'(o * 4);
    bus.WriteData = d;
    bus.MemWrite = 1'b1;
    bus.MemRead = 1'b0;
    step();
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd(input int o, output logic [31:0] v);
    bus.Address = BASE + 32'(o * 4);
    bus.MemRead = 1'b1;
    bus.MemWrite = 1'b0;
    #1;
    v = bus.ReadData;
  endtask

  logic [31:0] v;
  logic [31:0] e_set, e_clr;
  logic        e_sel;

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;
    #1;

    chk("reset_PortOut", PortOut, 32'h0);
    chk("reset_InChanged", {31'h0, InChanged}, 32'h0);
    rd(2, v); chk("reset_STATUS", v, 32'h0);
    step();

    wr(0, 32'hDEADBEEF);
    chk("store_PortOut", PortOut, 32'hDEADBEEF);
    rd(0, v); chk("load_PORTOUT", v, 32'hDEADBEEF);
    chk("load_IOSel", {31'h0, bus.IOSel}, 32'h1);
    step();

    PortIn = 8'h3C;
    rd(1, v); chk("pin_t0", v, 32'h0);
    step(); rd(1, v); chk("pin_t1", v, 32'h0);
    step(); rd(1, v); chk("pin_t2", v, 32'h3C);
    chk("pin_t2_flag", {31'h0, InChanged}, 32'h0);
    step();
    chk("pin_t3_flag", {31'h0, InChanged}, 32'h1);
    rd(2, v); chk("pin_t3_status", v, 32'h0101);

    PortIn = 8'h3D;
    step(); step();
    wr(2, 32'h1);
    rd(2, v); chk("setwins_status", v, 32'h0201);
    chk("setwins_flag", {31'h0, InChanged}, 32'h1);

    wr(0, 32'hA5);
    PortIn = 8'h3E;
    step(); step(); step();
    rd(2, v); chk("prereset_status", v, 32'h0301);
    chk("prereset_PortOut", PortOut, 32'hA5);
    rst_n = 1'b0;
    #1;
    chk("async_PortOut", PortOut, 32'h0);
    chk("async_InChanged", {31'h0, InChanged}, 32'h0);
    chk("async_STATUS", bus.ReadData, 32'h0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    rd(2, v); chk("postreset_event", v, 32'h0101);

    wr(2, 32'h3);
    rd(2, v); chk("clear_both", v, 32'h0);
    idle();
    for (int i = 0; i < 256; i++) begin
      PortIn = PortIn ^ 8'h01;
      step();
    end
    step(); step(); step();
    rd(2, v); chk("wrap_256", v, 32'h0001);
    PortIn = PortIn ^ 8'h01;
    step(); step(); step();
    rd(2, v); chk("wrap_plus1", v, 32'h0101);
    wr(2, 32'h2);
    rd(2, v); chk("clear_cnt_only", v, 32'h0001);
    chk("clear_cnt_flag", {31'h0, InChanged}, 32'h1);

`ifdef IO_PORTOUT_SETCLR_EN
    e_sel = 1'b1; e_set = 32'hFF; e_clr = 32'hC3;
`else
    e_sel = 1'b0; e_set = 32'h0F; e_clr = 32'h0F;
`endif
    wr(0, 32'h0F);
    bus.Address = BASE + 32'h0C; bus.WriteData = 32'hF0;
    bus.MemWrite = 1'b1; #1;
    chk("set_IOSel", {31'h0, bus.IOSel}, {31'h0, e_sel});
    step(); bus.MemWrite = 1'b0;
    chk("set_PortOut", PortOut, e_set);
    bus.Address = BASE + 32'h10; bus.WriteData = 32'h3C;
    bus.MemWrite = 1'b1; #1;
    chk("clr_IOSel", {31'h0, bus.IOSel}, {31'h0, e_sel});
    step(); bus.MemWrite = 1'b0;
    chk("clr_PortOut", PortOut, e_clr);
    rd(3, v); chk("set_reads0", v, 32'h0);
    step();

    for (int c = 0; c < 600; c++) begin
      automatic int k = int'($urandom_range(0, 7));
      if (k == 0) bus.Address = $urandom;
      else if (k == 1)
        bus.Address = BASE ^ (32'h1 << $urandom_range(5, 31));
      else
        bus.Address = BASE + (32'($urandom_range(0, 7)) << 2)
                    + 32'($urandom_range(0, 3));
      bus.WriteData = $urandom;
      bus.MemWrite = $urandom_range(0, 2) == 0;
      bus.MemRead = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) PortIn = 8'($urandom);
      if (c == 300) rst_n = 1'b0;
      if (c == 302) rst_n = 1'b1;
      step();
    end

    idle();
    step();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
